beinmotion_qsys_cpu_oci_dct_packer: RTL and testbench

//   Upstream producer of dct_buffer/dct_count for the OCI test-bench monitor.

---
 rtl/beinmotion_qsys_cpu_oci_dct_packer_pkg.sv | 23 ++
 rtl/beinmotion_qsys_cpu_oci_dct_packer_if.sv | 34 +++
 rtl/beinmotion_qsys_cpu_oci_dct_packer_frame_reg.sv | 65 ++++++
 rtl/beinmotion_qsys_cpu_oci_dct_packer.sv | 107 ++++++++++
 tb/tb_beinmotion_qsys_cpu_oci_dct_packer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beinmotion_qsys_cpu_oci_dct_packer_pkg.sv
// rtl/beinmotion_qsys_cpu_oci_dct_packer_pkg.sv - shared constants and types for the OCI DCT packer
//
// Purpose: frame geometry constants and the output-stage state type used by
//          the packer top, its frame register and its bus interface.
// Contents:
//   SYM_W   bits per trace symbol
//   SLOTS   symbols per frame
//   CNT_W   width of a symbol count (holds SLOTS)
//   DCT_W   frame width, SYM_W*SLOTS
//   out_state_t  output holding register state {EMPTY, HOLD}
package beinmotion_qsys_cpu_oci_dct_pkg;

  localparam int SYM_W = 2;
  localparam int SLOTS = 15;
  localparam int CNT_W = 4;
  localparam int DCT_W = SYM_W * SLOTS;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/beinmotion_qsys_cpu_oci_dct_packer_if.sv
// rtl/beinmotion_qsys_cpu_oci_dct_packer_if.sv - symbol-in / frame-out bus of the OCI DCT packer
//
// Purpose: bundles the trace-symbol handshake and the frame handshake.
// Signals:
//   sym_valid, sym_data   symbol offered by the trace source
//   sym_ready             packer accepts the symbol this cycle
//   dct_buffer, dct_count frame contents and number of valid symbols
//   frame_valid           frame presented to the consumer
//   frame_ready           consumer takes the frame this cycle
// Modports:
//   master  environment side (trace source + frame consumer)
//   slave   packer side
interface beinmotion_qsys_cpu_oci_dct_packer_if;
  import beinmotion_qsys_cpu_oci_dct_pkg::*;

  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             frame_valid;
  logic             frame_ready;

  modport master (
    output sym_valid, sym_data, frame_ready,
    input  sym_ready, dct_buffer, dct_count, frame_valid
  );

  modport slave (
    input  sym_valid, sym_data, frame_ready,
    output sym_ready, dct_buffer, dct_count, frame_valid
  );

endinterface

// File: rtl/beinmotion_qsys_cpu_oci_dct_packer_frame_reg.sv
// rtl/beinmotion_qsys_cpu_oci_dct_packer_frame_reg.sv - output holding register with EMPTY/HOLD handshake FSM
//
// Purpose: holds one packed frame until the consumer takes it, and tells the
//          parent when a new frame may be loaded.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   load                      copy load_buffer/load_count into the register
//   load_buffer, load_count   frame from the accumulator
//   frame_ready               consumer takes the presented frame
//   dct_buffer, dct_count     held frame
//   frame_valid               a frame is being presented
//   out_free                  a load is allowed this cycle
module beinmotion_qsys_cpu_oci_dct_frame_reg
  import beinmotion_qsys_cpu_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DCT_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             frame_ready,
  output logic [DCT_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             frame_valid,
  output logic             out_free
);

  out_state_t state;
  out_state_t state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A load while HOLD is only possible when the consumer takes the current
  // frame in the same cycle, so HOLD simply persists with the new contents.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (load) state_next = HOLD;
      HOLD:  if (frame_ready && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    frame_valid = (state == HOLD);
    out_free    = (state == EMPTY) || ((state == HOLD) && frame_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
    end
  end

endmodule

// File: rtl/beinmotion_qsys_cpu_oci_dct_packer.sv
// rtl/beinmotion_qsys_cpu_oci_dct_packer.sv - packs 2-bit trace symbols into 30-bit frames for the OCI monitor
//
// Purpose: accumulates trace symbols (newest in the low slot), hands full or
//          flushed frames to a double-buffered output register, and raises
//          test_has_ended once test_ending is seen with all trace drained.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset (released synchronously upstream)
//   bus              slave side of the symbol/frame interface
//   flush            1-cycle pulse: emit the partial frame
//   test_ending      level: acts as a continuous flush
//   test_has_ended   registered end-of-test indication
//   frame_total      count of frames handed over (saturating)
// Build option:
//   BEINMOTION_OCI_DCT_STATS_EN  when defined, frame_total counts frame
//                                handshakes; otherwise it is tied to zero.
module beinmotion_qsys_cpu_oci_dct_packer
  import beinmotion_qsys_cpu_oci_dct_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  beinmotion_qsys_cpu_oci_dct_packer_if.slave   bus,
  input  logic                                  flush,
  input  logic                                  test_ending,
  output logic                                  test_has_ended,
  output logic [15:0]                           frame_total
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

  logic [DCT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;
  logic             out_free;
  logic             acc_full;
  logic             acc_empty;
  logic             accept;
  logic             transfer;

  assign acc_full  = (cnt == CNT_FULL);
  assign acc_empty = (cnt == '0);

  // Only stall the source when the accumulator is full and cannot drain.
  assign bus.sym_ready = !(acc_full && !out_free);
  assign accept        = bus.sym_valid && bus.sym_ready;
  assign transfer      = (acc_full || ((flush_pend || test_ending) && !acc_empty)) && out_free;

  // A symbol accepted while the accumulator drains starts the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (transfer) begin
      acc <= accept ? DCT_W'(bus.sym_data) : '0;
      cnt <= accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      acc <= {acc[DCT_W-SYM_W-1:0], bus.sym_data};
      cnt <= cnt + 1'b1;
    end
  end

  // A flush applies to whatever will be in the accumulator next cycle:
  // nothing to do if it is draining now and no new symbol arrives, and a
  // flush with an empty accumulator and no arriving symbol is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else if (flush && (accept || (!acc_empty && !transfer))) begin
      flush_pend <= 1'b1;
    end else if (transfer || (acc_empty && !accept)) begin
      flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_has_ended <= 1'b0;
    end else begin
      test_has_ended <= test_ending && acc_empty && !bus.frame_valid;
    end
  end

  beinmotion_qsys_cpu_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (transfer),
    .load_buffer (acc),
    .load_count  (cnt),
    .frame_ready (bus.frame_ready),
    .dct_buffer  (bus.dct_buffer),
    .dct_count   (bus.dct_count),
    .frame_valid (bus.frame_valid),
    .out_free    (out_free)
  );

`ifdef BEINMOTION_OCI_DCT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_total <= '0;
    end else if (bus.frame_valid && bus.frame_ready && (frame_total != 16'hFFFF)) begin
      frame_total <= frame_total + 16'd1;
    end
  end
`else
  assign frame_total = 16'h0000;
`endif

endmodule

// File: tb/tb_beinmotion_qsys_cpu_oci_dct_packer.sv
// tb/tb_beinmotion_qsys_cpu_oci_dct_packer.sv - self-checking bench for the OCI DCT packer
module tb_beinmotion_qsys_cpu_oci_dct_packer;
  import beinmotion_qsys_cpu_oci_dct_pkg::*;

`ifdef BEINMOTION_OCI_DCT_STATS_EN
  localparam int EXP_T6_TOTAL = 2;
`else
  localparam int EXP_T6_TOTAL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic        test_has_ended;
  logic [15:0] frame_total;

  beinmotion_qsys_cpu_oci_dct_packer_if bus ();

  beinmotion_qsys_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .frame_total    (frame_total)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Written only by the monitor.
  logic [1:0]       sym_q   [$];
  logic [DCT_W-1:0] got_buf [$];
  logic [CNT_W-1:0] got_cnt [$];
  int               stab_bad = 0;
  logic             prev_hold = 1'b0;
  logic [DCT_W-1:0] prev_buf = '0;
  logic [CNT_W-1:0] prev_cnt = '0;

  // Written only by the stimulus block.
  logic [1:0]       stim [$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.sym_valid && bus.sym_ready) sym_q.push_back(bus.sym_data);
      if (bus.frame_valid && bus.frame_ready) begin
        got_buf.push_back(bus.dct_buffer);
        got_cnt.push_back(bus.dct_count);
      end
      if (prev_hold && (!bus.frame_valid || bus.dct_buffer !== prev_buf || bus.dct_count !== prev_cnt))
        stab_bad <= stab_bad + 1;
      prev_hold <= bus.frame_valid && !bus.frame_ready;
      prev_buf  <= bus.dct_buffer;
      prev_cnt  <= bus.dct_count;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  // Frame value from a symbol list: first symbol ends up most significant.
  function automatic logic [DCT_W-1:0] pack(input logic [1:0] q[$], input int start, input int n);
    logic [DCT_W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v * 4 + DCT_W'(q[start + i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = s;
    for (int k = 0; k < 100 && !ok; k++) begin
      #2;
      ok = bus.sym_ready;
      tick();
    end
    bus.sym_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic new_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(2'($urandom_range(0, 3)));
  endtask

  initial begin
    int base;
    int idx;
    int rem;
    int n;

    bus.sym_valid   = 1'b0;
    bus.sym_data    = 2'b00;
    bus.frame_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_dct_buffer", bus.dct_buffer, 0);
    chk("rst_dct_count", bus.dct_count, 0);
    chk("rst_frame_valid", bus.frame_valid, 0);
    chk("rst_test_has_ended", test_has_ended, 0);
    chk("rst_frame_total", frame_total, 0);
    chk("rst_sym_ready", bus.sym_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: reset while a frame is held and 7 more symbols sit in the accumulator
    for (int i = 0; i < 15; i++) send_sym(2'b11);
    for (int i = 0; i < 7; i++) send_sym(2'b01);
    chk("t1_held_valid", bus.frame_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_async_frame_valid", bus.frame_valid, 0);
    chk("t1_async_dct_buffer", bus.dct_buffer, 0);
    chk("t1_async_dct_count", bus.dct_count, 0);
    chk("t1_async_sym_ready", bus.sym_ready, 1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_sym(2'b10);
    tick();
    chk("t1_after_valid", bus.frame_valid, 1);
    chk("t1_after_count", bus.dct_count, 15);
    chk("t1_after_buffer", bus.dct_buffer, 32'h2AAA_AAAA);
    tick();

    // 2: full frame latency and contents
    for (int i = 0; i < 15; i++) send_sym(2'b01);
    chk("t2_valid_at_n1", bus.frame_valid, 0);
    tick();
    chk("t2_valid_at_n2", bus.frame_valid, 1);
    chk("t2_buffer", bus.dct_buffer, 32'h1555_5555);
    chk("t2_count", bus.dct_count, 15);
    tick();
    chk("t2_valid_one_cycle", bus.frame_valid, 0);

    // 3: partial flush, then a flush with nothing to send
    send_sym(2'd3);
    send_sym(2'd2);
    send_sym(2'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_not_yet", bus.frame_valid, 0);
    tick();
    chk("t3_valid", bus.frame_valid, 1);
    chk("t3_buffer", bus.dct_buffer, 32'h39);
    chk("t3_count", bus.dct_count, 3);
    tick();
    base = got_buf.size();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("t3_empty_flush_frames", got_buf.size() - base, 0);
    chk("t3_empty_flush_valid", bus.frame_valid, 0);

    // 4: backpressure with 30 symbols
    bus.frame_ready = 1'b0;
    new_stim(30);
    base = got_buf.size();
    for (int i = 0; i < 30; i++) send_sym(stim[i]);
    chk("t4_sym_ready_full", bus.sym_ready, 0);
    chk("t4_held_valid", bus.frame_valid, 1);
    chk("t4_held_buffer", bus.dct_buffer, pack(stim, 0, 15));
    repeat (3) tick();
    chk("t4_still_buffer", bus.dct_buffer, pack(stim, 0, 15));
    bus.frame_ready = 1'b1;
    repeat (4) tick();
    chk("t4_frames", got_buf.size() - base, 2);
    chk("t4_frame0", got_buf[base], pack(stim, 0, 15));
    chk("t4_frame1", got_buf[base + 1], pack(stim, 15, 15));
    chk("t4_count1", got_cnt[base + 1], 15);

    // 5: frame taken while the accumulator is full, with a symbol accepted in the same cycle
    bus.frame_ready = 1'b0;
    new_stim(31);
    base = got_buf.size();
    for (int i = 0; i < 30; i++) send_sym(stim[i]);
    bus.frame_ready = 1'b1;
    #1;
    chk("t5_ready_when_free", bus.sym_ready, 1);
    chk("t5_first_buffer", bus.dct_buffer, pack(stim, 0, 15));
    send_sym(stim[30]);
    chk("t5_valid_no_drop", bus.frame_valid, 1);
    chk("t5_second_buffer", bus.dct_buffer, pack(stim, 15, 15));
    chk("t5_second_count", bus.dct_count, 15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("t5_frames", got_buf.size() - base, 3);
    chk("t5_single_buffer", got_buf[base + 2], pack(stim, 30, 1));
    chk("t5_single_count", got_cnt[base + 2], 1);

    // 6: end-of-test drain with a pending frame and 4 symbols in the accumulator
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    new_stim(19);
    base = got_buf.size();
    for (int i = 0; i < 19; i++) send_sym(stim[i]);
    chk("t6_pending", bus.frame_valid, 1);
    test_ending = 1'b1;
    tick();
    chk("t6_not_ended_pending", test_has_ended, 0);
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 20 && test_has_ended !== 1'b1; k++) tick();
    chk("t6_has_ended", test_has_ended, 1);
    chk("t6_frames", got_buf.size() - base, 2);
    chk("t6_frame0", got_buf[base], pack(stim, 0, 15));
    chk("t6_frame1", got_buf[base + 1], pack(stim, 15, 4));
    chk("t6_count1", got_cnt[base + 1], 4);
    chk("t6_frame_total", frame_total, EXP_T6_TOTAL);
    test_ending = 1'b0;
    tick();
    tick();
    chk("t6_ended_drops", test_has_ended, 0);

    // Randomized traffic: every accepted symbol appears once, in order, in 15-symbol frames
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    idx  = sym_q.size();
    base = got_buf.size();
    for (int c = 0; c < 1500; c++) begin
      bus.sym_valid   = ($urandom_range(0, 3) != 0);
      bus.sym_data    = 2'($urandom_range(0, 3));
      bus.frame_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.sym_valid   = 1'b0;
    bus.frame_ready = 1'b1;
    test_ending     = 1'b1;
    for (int k = 0; k < 50 && test_has_ended !== 1'b1; k++) tick();
    chk("rand_has_ended", test_has_ended, 1);
    for (int f = base; f < got_buf.size(); f++) begin
      rem = sym_q.size() - idx;
      n   = (rem < SLOTS) ? rem : SLOTS;
      chk("rand_count", got_cnt[f], n);
      chk("rand_buffer", got_buf[f], pack(sym_q, idx, n));
      idx += n;
    end
    chk("rand_all_drained", sym_q.size() - idx, 0);
    chk("hold_stable", stab_bad, 0);
    test_ending = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
